// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial lookahead adder.
package cla_pkg;
  localparam int NIBW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cla.sv
// Combinational 4-bit carry-lookahead cell; c[i] is the carry out of bit i.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic [3:0] c
);
  logic [3:0] g;
  logic [3:0] p;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = g[0] | (p[0] & ci);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c[2:0], ci};
endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial adder: result NIB+1 edges after accept, held until out_ready; one op per NIB+2 cycles.
// Define CLA_SEQ_SUB_EN to enable op=1 subtraction (a + ~b + 1).
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / NIBW;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              cin_q, sub_q, carry_q, cout_q, ovf_q;

  logic [NIBW-1:0]   nib_a, nib_b, nib_s, nib_c;
  logic              nib_ci;
  logic [1:0]        unused_c;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = RUN;
      RUN:     if (k_q == K_LAST)   state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Subtraction inverts b per nibble and forces the first carry-in high.
  assign nib_a    = a_q[int'(k_q)*NIBW +: NIBW];
  assign nib_b    = b_q[int'(k_q)*NIBW +: NIBW] ^ {NIBW{sub_q}};
  assign nib_ci   = (k_q == '0) ? (sub_q | cin_q) : carry_q;
  assign unused_c = nib_c[1:0];

  cla u_cla (
    .a  (nib_a),
    .b  (nib_b),
    .ci (nib_ci),
    .s  (nib_s),
    .c  (nib_c)
  );

`ifndef CLA_SEQ_SUB_EN
  logic unused_op;
  assign unused_op = op;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
`ifdef CLA_SEQ_SUB_EN
      sub_q <= op;
`else
      sub_q <= 1'b0;
`endif
      k_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[int'(k_q)*NIBW +: NIBW] <= nib_s;
      carry_q <= nib_c[3];
      k_q     <= k_q + 1'b1;
      if (k_q == K_LAST) begin
        cout_q <= nib_c[3];
        ovf_q  <= nib_c[3] ^ nib_c[2];
      end
    end
  end
endmodule
